pid_pwm_driver: RTL and testbench
=================================

Name: pid_pwm_driver

Overview:
Downstream stage of the PID top. Consumes the control variable u produced by the P+I+D sum and converts it into a fixed-frequency PWM waveform for the actuator pin.
- New u values arrive over a valid/ready handshake into a one-entry pending buffer.
- A pending value is applied only at a period boundary, so the driver never emits glitch pulses.
- A period_start strobe tells upstream sampling logic when to take the next error sample.

Parameters:
U_W, 6, width of u and of the PWM period counter
PRESC_W, 8, width of the clock prescaler
DT_CYC, 2, dead-time length in clk cycles (used only with PWM_DEADTIME_EN)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
ena  in  1  run enable; low freezes counters and forces outputs inactive
presc_div  in  PRESC_W  tick divider; one tick every presc_div+1 clk cycles
u  in  U_W  unsigned control value (duty in ticks)
u_valid  in  1  u is valid
u_ready  out  1  pending buffer empty, can accept u
pwm_hi  out  1  high-side PWM output
pwm_lo  out  1  low-side complementary output (0 without PWM_DEADTIME_EN)
period_start  out  1  one-clk pulse at each period boundary
duty_active  out  U_W  duty currently being generated

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - prescaler=0, cnt=0, pending empty, duty_active=0
  - pwm_hi=0, pwm_lo=0, period_start=0, u_ready=1
- A mid-period reset aborts the period at once; the pending value is discarded.
- Prescaler:
  - Increments each clk while ena=1.
  - When prescaler >= presc_div: tick=1 and prescaler<=0.
  - Using >= means lowering presc_div mid-run never stalls the prescaler.
- Period counter cnt:
  - Advances on tick.
  - Wraps from 2^U_W-2 to 0, giving a period of 2^U_W-1 ticks (63 for U_W=6).
- Period boundary (tick while cnt=2^U_W-2):
  - period_start pulses high for 1 clk.
  - If pending is full: duty_active<=pending and pending is cleared.
- Handshake:
  - u_ready = pending empty.
  - On u_valid & u_ready, u is captured into pending.
  - u is ignored while u_ready=0; upstream must hold u_valid.
- Simultaneous capture and boundary with pending empty: the value is captured, but it applies only at the next boundary. There is no bypass.
- Simultaneous boundary and a full pending buffer: the buffer drains and u_ready rises the next cycle.
- Raw PWM: raw = (cnt < duty_active).
  - pwm_hi is registered from raw, so it lags cnt by 1 clk.
  - duty 0 gives constant low.
  - duty 2^U_W-1 gives constant high with no gap at the wrap.
- ena=0:
  - prescaler and cnt hold their values.
  - pwm_hi=0, pwm_lo=0 and period_start=0 from the next cycle.
  - Handshake still operates.
  - When ena returns to 1, counting resumes from the held cnt.

Optional Feature:
PWM_DEADTIME_EN
- Defined:
  - pwm_lo is driven as the complement of raw.
  - On any raw edge, the output that is turning off deasserts immediately.
  - The output that is turning on asserts only after raw has been stable for DT_CYC clk cycles, counted by a dead-time counter.
  - A raw pulse shorter than DT_CYC never asserts the turning-on output.
  - pwm_hi and pwm_lo are never high in the same cycle.
- Undefined: pwm_lo is tied to 0, the dead-time logic is absent, and pwm_hi follows the base registered behaviour.

Decomposition:
- Shared package pid_pkg: U_W default constant, ctrl_t typedef (logic [U_W-1:0]), PRESC_W constant.
- One natural sub-module: pid_deadtime_gen (raw in → hi/lo out, DT_CYC counter). It is instantiated only under PWM_DEADTIME_EN.

Test Plan:
- Reset value: assert rst_n=0 for 3 clk → all outputs 0, u_ready=1.
- Single duty: presc_div=0, send u=21 → after the first period_start, pwm_hi is high 21 clk and low 42 clk per 63-clk period; duty_active=21.
- Extremes: u=0 → pwm_hi constantly 0; u=63 → pwm_hi constantly 1 across the wrap; period_start every 63 clk.
- Handshake backpressure: send u=10, then hold u_valid with u=40 → u_ready=0 until the boundary; 10 applies first, 40 is captured after the drain and applies one period later.
- Prescaler and ena: presc_div=3 → period_start every 252 clk. Drop ena for 20 clk mid-period → outputs 0 and the period stretches by exactly 20 clk.
- Dead time (PWM_DEADTIME_EN, DT_CYC=2): u=21 → pwm_hi and pwm_lo never both high; each turn-on is delayed 2 clk after the raw edge; a 1-tick raw pulse (u=1) gives pwm_hi=0.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared constants and types for the PID controller datapath.
package pid_pkg;

  localparam int unsigned PID_U_W     = 6;
  localparam int unsigned PID_PRESC_W = 8;
  localparam int unsigned PID_DT_CYC  = 2;

  typedef logic [PID_U_W-1:0] ctrl_t;

  // Last count value of a period: the counter wraps after 2^w-1 ticks.
  function automatic int unsigned period_last(input int unsigned w);
    return (2 ** w) - 2;
  endfunction

endpackage

// File: rtl/pid_deadtime_gen.sv
// Complementary hi/lo generator: turn-off is immediate, turn-on waits until
// raw has been stable for DT_CYC clk cycles.
module pid_deadtime_gen #(
  parameter int unsigned DT_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic raw_i,
  output logic hi_o,
  output logic lo_o
);

  localparam int unsigned CntW = (DT_CYC > 0) ? $clog2(DT_CYC + 1) : 1;
  localparam logic [CntW-1:0] DtMax = CntW'(DT_CYC);

  logic            prev_q, prev_d;
  logic [CntW-1:0] stable_q, stable_d;
  logic            hi_q, hi_d;
  logic            lo_q, lo_d;
  logic            settled;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q   <= 1'b0;
      stable_q <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // A raw edge restarts the stability count, which drops both outputs at once.
  always_comb begin
    prev_d   = raw_i;
    stable_d = stable_q;
    if (raw_i != prev_q) begin
      stable_d = '0;
    end else if (stable_q != DtMax) begin
      stable_d = stable_q + CntW'(1);
    end
    settled = (stable_d >= DtMax);
    hi_d    = en_i & raw_i & settled;
    lo_d    = en_i & ~raw_i & settled;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/pid_pwm_driver.sv
// Fixed-frequency PWM driver with a one-entry pending duty buffer applied at
// period boundaries. Define PWM_DEADTIME_EN for complementary outputs with dead time.
module pid_pwm_driver
  import pid_pkg::*;
#(
  parameter int unsigned U_W     = PID_U_W,
  parameter int unsigned PRESC_W = PID_PRESC_W,
  parameter int unsigned DT_CYC  = PID_DT_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic [U_W-1:0]     u,
  input  logic               u_valid,
  output logic               u_ready,
  output logic               pwm_hi,
  output logic               pwm_lo,
  output logic               period_start,
  output logic [U_W-1:0]     duty_active
);

  localparam logic [U_W-1:0] CntLast = U_W'(period_last(U_W));

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [U_W-1:0]     cnt_q, cnt_d;
  logic [U_W-1:0]     pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [U_W-1:0]     duty_q, duty_d;
  logic               pstart_q, pstart_d;
  logic               tick;
  logic               boundary;
  logic               raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      duty_q     <= '0;
      pstart_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      duty_q     <= duty_d;
      pstart_q   <= pstart_d;
    end
  end

  always_comb begin
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    duty_d     = duty_q;
    tick       = 1'b0;
    boundary   = 1'b0;
    // >= so that lowering presc_div mid-run cannot strand the prescaler above it
    if (ena) begin
      if (presc_q >= presc_div) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
    if (tick) begin
      if (cnt_q == CntLast) begin
        boundary = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + U_W'(1);
      end
    end
    pstart_d = boundary;
    // Drain and capture are mutually exclusive: capture needs an empty buffer.
    if (boundary && pend_vld_q) begin
      duty_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (u_valid && !pend_vld_q) begin
      pend_d     = u;
      pend_vld_d = 1'b1;
    end
  end

  assign raw          = (cnt_q < duty_q);
  assign u_ready      = ~pend_vld_q;
  assign period_start = pstart_q;
  assign duty_active  = duty_q;

`ifdef PWM_DEADTIME_EN
  pid_deadtime_gen #(
    .DT_CYC (DT_CYC)
  ) u_deadtime (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ena),
    .raw_i (raw),
    .hi_o  (pwm_hi),
    .lo_o  (pwm_lo)
  );
`else
  logic        hi_q, hi_d;
  logic [31:0] dt_cyc_unused;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
    end
  end

  always_comb begin
    hi_d = ena & raw;
  end

  assign dt_cyc_unused = DT_CYC;
  assign pwm_hi        = hi_q;
  assign pwm_lo        = 1'b0;
`endif

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Self-checking bench for pid_pwm_driver: randomized duty/prescaler runs
// compared against a period-level model of the PWM waveform.
module tb_pid_pwm_driver;
  import pid_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   ena;
  logic [PID_PRESC_W-1:0] presc_div;
  ctrl_t                  u;
  logic                   u_valid;
  logic                   u_ready;
  logic                   pwm_hi;
  logic                   pwm_lo;
  logic                   period_start;
  ctrl_t                  duty_active;

  int checks = 0;
  int errors = 0;
  int prev_duty = 0;

  always #5 clk = ~clk;

  pid_pwm_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .presc_div    (presc_div),
    .u            (u),
    .u_valid      (u_valid),
    .u_ready      (u_ready),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  // Base PWM level seen at sample j after a period_start sample (j=0).
  // Sample j reflects the count position of clk index j-1; positions advance
  // every p clk, 63 positions per period; j<=0 belongs to the previous period.
  function automatic logic exp_base(input int j, input int d, input int p, input int prev);
    if (j >= 1) return ((j - 1) / p) < d;
    return (((j - 1) + 63 * p) / p) < prev;
  endfunction

  task automatic send_u(input int val);
    bit done = 0;
    u       = ctrl_t'(val);
    u_valid = 1'b1;
    for (int k = 0; k < 20000 && !done; k++) begin
      if (u_ready) done = 1;
      @(negedge clk);
    end
    u_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout u=%0d never accepted", val);
    end
  endtask

  task automatic wait_ps();
    bit seen = 0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk);
      if (period_start) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL period_start_timeout no pulse within bound");
    end
  endtask

  // Checks one full period starting at the current period_start sample.
  task automatic check_period(input int d, input int p, input int prev);
    logic eh, el, eps;
    for (int j = 0; j <= 63 * p; j++) begin
      if (j > 0) @(negedge clk);
`ifdef PWM_DEADTIME_EN
      eh = exp_base(j, d, p, prev) & exp_base(j - 1, d, p, prev) & exp_base(j - 2, d, p, prev);
      el = ~exp_base(j, d, p, prev) & ~exp_base(j - 1, d, p, prev) & ~exp_base(j - 2, d, p, prev);
      checks++;
      if ((pwm_hi & pwm_lo) !== 1'b0) begin
        errors++;
        $display("FAIL overlap d=%0d j=%0d hi=%b lo=%b", d, j, pwm_hi, pwm_lo);
      end
`else
      eh = exp_base(j, d, p, prev);
      el = 1'b0;
`endif
      eps = (j == 0) || (j == 63 * p);
      checks++;
      if (pwm_hi !== eh) begin
        errors++;
        $display("FAIL pwm_hi d=%0d p=%0d j=%0d got %b exp %b", d, p, j, pwm_hi, eh);
      end
      checks++;
      if (pwm_lo !== el) begin
        errors++;
        $display("FAIL pwm_lo d=%0d p=%0d j=%0d got %b exp %b", d, p, j, pwm_lo, el);
      end
      checks++;
      if (period_start !== eps) begin
        errors++;
        $display("FAIL period_start d=%0d p=%0d j=%0d got %b exp %b", d, p, j, period_start, eps);
      end
      checks++;
      if (duty_active !== ctrl_t'(d)) begin
        errors++;
        $display("FAIL duty_active j=%0d got %0d exp %0d", j, duty_active, d);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; u_valid = 1'b0; u = '0; presc_div = '0;
    repeat (3) @(negedge clk);
    checks++; if (pwm_hi !== 1'b0) begin errors++; $display("FAIL reset_pwm_hi got %b exp 0", pwm_hi); end
    checks++; if (pwm_lo !== 1'b0) begin errors++; $display("FAIL reset_pwm_lo got %b exp 0", pwm_lo); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start got %b exp 0", period_start); end
    checks++; if (duty_active !== '0) begin errors++; $display("FAIL reset_duty got %0d exp 0", duty_active); end
    checks++; if (u_ready !== 1'b1) begin errors++; $display("FAIL reset_u_ready got %b exp 1", u_ready); end
    rst_n = 1'b1;
    ena   = 1'b1;
    wait_ps();
    prev_duty = 0;
  endtask

  // Duties including both extremes; 63 twice so the wrap is seen fully high.
  task automatic test_duty();
    int dl[8] = '{21, 0, 63, 63, 0, 0, 0, 0};
    int pl[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 4; i < 8; i++) begin
      dl[i] = $urandom_range(63, 0);
      pl[i] = $urandom_range(4, 1);
    end
    for (int i = 0; i < 8; i++) begin
      presc_div = PID_PRESC_W'(pl[i] - 1);
      send_u(dl[i]);
      wait_ps();
      check_period(dl[i], pl[i], prev_duty);
      prev_duty = dl[i];
    end
  endtask

  task automatic test_back_to_back();
    int  p = 2;
    bit  seen = 0;
    presc_div = PID_PRESC_W'(p - 1);
    send_u(prev_duty);
    wait_ps();
    u = ctrl_t'(10); u_valid = 1'b1;
    @(negedge clk);
    u = ctrl_t'(40);
    checks++;
    if (u_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_capture got %b exp 0", u_ready); end
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      if (period_start) seen = 1;
      else if (u_ready !== 1'b0) begin
        checks++; errors++;
        $display("FAIL bp_ready_held k=%0d got %b exp 0", k, u_ready);
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_boundary_timeout"); end
    checks++;
    if (duty_active !== ctrl_t'(10)) begin errors++; $display("FAIL bp_first_duty got %0d exp 10", duty_active); end
    checks++;
    if (u_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_drain got %b exp 1", u_ready); end
    @(negedge clk);
    u_valid = 1'b0;
    checks++;
    if (u_ready !== 1'b0) begin errors++; $display("FAIL bp_second_capture got %b exp 0", u_ready); end
    wait_ps();
    check_period(40, p, 10);
    prev_duty = 40;
  endtask

  task automatic test_ena();
    int j;
    bit seen = 0;
    presc_div = PID_PRESC_W'(3);
    send_u(63);
    wait_ps();
    for (j = 1; j <= 100; j++) @(negedge clk);
    j = 100;
    ena = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); j++;
      checks++;
      if ((pwm_hi | pwm_lo | period_start) !== 1'b0) begin
        errors++;
        $display("FAIL ena_off_outputs j=%0d got hi=%b lo=%b ps=%b exp 0", j, pwm_hi, pwm_lo, period_start);
      end
    end
    ena = 1'b1;
    @(negedge clk); j++;
    checks++;
    if (pwm_hi !== 1'b1) begin errors++; $display("FAIL ena_resume_hi got %b exp 1", pwm_hi); end
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk); j++;
      if (period_start) seen = 1;
    end
    checks++;
    if (!seen || j != 272) begin errors++; $display("FAIL ena_period_len got %0d exp 272", j); end
    check_period(63, 4, 63);
    prev_duty = 63;
  endtask

  task automatic test_midreset();
    send_u(33);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (duty_active !== '0) begin errors++; $display("FAIL mrst_duty got %0d exp 0", duty_active); end
    checks++; if (u_ready !== 1'b1) begin errors++; $display("FAIL mrst_u_ready got %b exp 1", u_ready); end
    checks++; if (pwm_hi !== 1'b0) begin errors++; $display("FAIL mrst_pwm_hi got %b exp 0", pwm_hi); end
    wait_ps();
    check_period(0, 4, 0);
    prev_duty = 0;
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic test_deadtime();
    presc_div = '0;
    send_u(21);
    wait_ps();
    check_period(21, 1, prev_duty);
    send_u(1);
    wait_ps();
    check_period(1, 1, 21);
    prev_duty = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_duty();
    test_back_to_back();
    test_ena();
    test_midreset();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
